// File: rtl/pwm_pkg.sv
// Shared defaults for the PWM generator and its serial-to-parallel output latch.
package pwm_pkg;
  localparam int CHANNELS_DEF = 10;
  localparam int FCNT_W_DEF   = 8;
endpackage

// File: rtl/pwm_sipo_latch_if.sv
// Serial frame input, control strobes and parallel PWM outputs of the SIPO latch.
interface pwm_sipo_latch_if
  import pwm_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int FCNT_W   = FCNT_W_DEF
);
  logic                s_in;
  logic                shift_en;
  logic                latch;
  logic                clr;
  logic                oe;
  logic                err_clr;
  logic [CHANNELS-1:0] pwm;
  logic                frame_err;
  logic [FCNT_W-1:0]   frame_cnt;

  modport master (
    output s_in, shift_en, latch, clr, oe, err_clr,
    input  pwm, frame_err, frame_cnt
  );

  modport slave (
    input  s_in, shift_en, latch, clr, oe, err_clr,
    output pwm, frame_err, frame_cnt
  );
endinterface

// File: rtl/latch_edge_detect.sv
// Rising-edge detector: registers the strobe and pulses for the one cycle it first reads high.
module latch_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);
  logic latch_q;
  logic latch_d;

  always_comb begin
    latch_d = d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) latch_q <= 1'b0;
    else          latch_q <= latch_d;
  end

  assign pulse = d & ~latch_q;
endmodule

// File: rtl/pwm_sipo_latch.sv
// Shifts serial PWM samples into a frame register and transfers whole frames to the
// output register on each latch edge, flagging frames whose bit count is wrong.
module pwm_sipo_latch
  import pwm_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int FCNT_W   = FCNT_W_DEF
) (
  input logic             clk,
  input logic             reset_n,
  pwm_sipo_latch_if.slave bus
);
  localparam int              CNT_W    = $clog2(CHANNELS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHANNELS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHANNELS);

  // Stops at CHANNELS+1 so an overlong frame can never wrap back to a "good" count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  logic [CHANNELS-1:0] sr_q, sr_d, sr_eff;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d, cnt_eff;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                frame_err_q, frame_err_d;
  logic                shift;
  logic                latch_edge;

  latch_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.latch),
    .pulse   (latch_edge)
  );

  always_comb begin
    // clr blocks the shift, so a coincident latch sees the pre-clear contents.
    shift       = bus.shift_en & ~bus.clr;
    sr_eff      = shift ? {sr_q[CHANNELS-2:0], bus.s_in} : sr_q;
    cnt_eff     = shift ? sat_inc(bit_cnt_q) : bit_cnt_q;
    sr_d        = bus.clr ? '0 : sr_eff;
    bit_cnt_d   = (bus.clr || latch_edge) ? '0 : cnt_eff;
    out_d       = latch_edge ? sr_eff : out_q;
    frame_cnt_d = latch_edge ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
    frame_err_d = frame_err_q;
    if (latch_edge && (cnt_eff != CNT_FULL)) frame_err_d = 1'b1;
    else if (bus.err_clr)                    frame_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      out_q       <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      out_q       <= out_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.pwm       = bus.oe ? out_q : '0;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_pwm_sipo_latch.sv
// Directed bench for pwm_sipo_latch with a reference model and a latch-event scoreboard.
module tb_pwm_sipo_latch;
  localparam int CH = 10;
  localparam int FW = 8;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          err;
    logic [FW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  exp_t          sb[$];
  logic          hist[$];
  int            nbits = 0;
  logic          m_err = 1'b0;
  logic [FW-1:0] m_cnt = '0;
  logic [CH-1:0] m_out = '0;
  logic          lat_prev = 1'b0;

  pwm_sipo_latch_if #(.CHANNELS(CH), .FCNT_W(FW)) bus ();

  pwm_sipo_latch #(.CHANNELS(CH), .FCNT_W(FW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Newest shifted bit lands in bit 0, older bits above it.
  function automatic logic [CH-1:0] last_bits();
    logic [CH-1:0] v = '0;
    for (int i = 0; i < CH; i++)
      if (hist.size() > i) v[i] = hist[hist.size()-1-i];
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    nbits = 0;
    m_err = 1'b0;
    m_cnt = '0;
    m_out = '0;
    lat_prev = 1'b0;
  endtask

  task automatic cyc(input logic b, input logic sh, input logic la, input logic cl, input logic ec);
    logic edge_ev;
    exp_t e;
    bus.s_in = b; bus.shift_en = sh; bus.latch = la; bus.clr = cl; bus.err_clr = ec;
    edge_ev = la && !lat_prev;
    lat_prev = la;
    if (sh && !cl) begin
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
      nbits++;
    end
    if (edge_ev) begin
      m_err = (nbits != CH) ? 1'b1 : (ec ? 1'b0 : m_err);
      m_cnt = m_cnt + 1'b1;
      m_out = last_bits();
      e.pwm = m_out; e.err = m_err; e.cnt = m_cnt;
      sb.push_back(e);
      nbits = 0;
    end else if (ec) begin
      m_err = 1'b0;
    end
    if (cl) begin
      hist.delete();
      nbits = 0;
    end
    @(posedge clk);
    #1;
    if (edge_ev) begin
      e = sb.pop_front();
      chk("sb_pwm", bus.pwm, bus.oe ? e.pwm : '0);
      chk("sb_err", bus.frame_err, e.err);
      chk("sb_cnt", bus.frame_cnt, e.cnt);
    end else begin
      chk("cyc_pwm", bus.pwm, bus.oe ? m_out : '0);
      chk("cyc_err", bus.frame_err, m_err);
      chk("cyc_cnt", bus.frame_cnt, m_cnt);
    end
    bus.s_in = 1'b0; bus.shift_en = 1'b0; bus.latch = 1'b0; bus.clr = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_latch();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.s_in = 1'b0; bus.shift_en = 1'b0; bus.latch = 1'b0;
    bus.clr = 1'b0; bus.err_clr = 1'b0; bus.oe = 1'b1;
    #12;
    chk("rst_pwm", bus.pwm, '0);
    chk("rst_err", bus.frame_err, 1'b0);
    chk("rst_cnt", bus.frame_cnt, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full frame, first bit shifted ends up in the MSB.
    shift_word(32'b1011000001, 10);
    do_latch();
    chk("full_pwm", bus.pwm, 32'b1011000001);
    chk("full_cnt", bus.frame_cnt, 32'd1);

    // Short frame keeps two older bits in the high positions.
    shift_word(32'b11001010, 8);
    do_latch();
    chk("short_pwm", bus.pwm, 32'b0111001010);
    chk("short_err", bus.frame_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("errclr", bus.frame_err, 1'b0);

    // Tenth bit shifted in the latch cycle completes the frame.
    shift_word(32'b011111111, 9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("coinc_pwm", bus.pwm, 32'h1FE);
    chk("coinc_err", bus.frame_err, 1'b0);
    shift_word(32'h2AA, 10);
    do_latch();

    // Overlong frame must not alias to a good count.
    shift_word(32'h1A5B, 13);
    shift_word(32'h0C3D, 13);
    do_latch();
    chk("long_err", bus.frame_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("set_wins", bus.frame_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Held strobe yields one transfer.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Output enable gating and clr isolation from the output register.
    shift_word(32'h3FF, 10);
    do_latch();
    bus.oe = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("oe0_pwm", bus.pwm, '0);
    bus.oe = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("oe1_pwm", bus.pwm, 32'h3FF);
    shift_word(32'b1010, 4);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_pwm", bus.pwm, 32'h3FF);
    shift_word(32'h155, 10);
    do_latch();

    // clr together with latch transfers the pre-clear frame.
    shift_word(32'b10011, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    shift_word(32'h0F0, 10);
    do_latch();

    // Asynchronous reset in the middle of a frame.
    shift_word(32'b101, 3);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_pwm", bus.pwm, '0);
    chk("arst_err", bus.frame_err, 1'b0);
    chk("arst_cnt", bus.frame_cnt, '0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    shift_word(32'h0F0, 10);
    do_latch();
    for (int i = 0; i < 255; i++) do_latch();
    chk("wrap_cnt", bus.frame_cnt, '0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_sipo_latch.md
PWM_SIPO_LATCH -- requirements
Module: pwm_sipo_latch

Interface
REQ-001 SHALL have parameter CHANNELS, default 10: number of PWM output channels (= bits per frame).
REQ-002 SHALL have parameter FCNT_W, default 8: width of frame counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_in  input  1  serial PWM sample bit from the upstream PWM generator.
REQ-006 SHALL have port shift_en  input  1  when high at a clk edge, s_in is shifted in.
REQ-007 SHALL have port latch  input  1  frame-transfer strobe, synchronous to clk, high for at least one clk edge.
REQ-008 SHALL have port clr  input  1  synchronous clear of the shift stage.
REQ-009 SHALL have port oe  input  1  output enable.
REQ-010 SHALL have port err_clr  input  1  synchronous clear of frame_err.
REQ-011 SHALL have port pwm  output  CHANNELS  latched parallel PWM outputs.
REQ-012 SHALL have port frame_err  output  1  sticky flag: a latch occurred with a bit count other than CHANNELS.
REQ-013 SHALL have port frame_cnt  output  FCNT_W  count of latch events.

Function
REQ-014 SHALL hold an internal shift register sr[CHANNELS-1:0]; on shift_en: sr <= {sr[CHANNELS-2:0], s_in}.
REQ-015 SHALL map shift order so that, after exactly CHANNELS shifts, the first bit shifted sits in sr[CHANNELS-1] and the last in sr[0].
REQ-016 SHALL keep bit_cnt (0..CHANNELS+1), incremented on each shift and saturating at CHANNELS+1.
REQ-017 SHALL detect the latch rising edge (latch high, registered latch_q low); a held-high latch produces exactly one transfer.
REQ-018 On a latch edge SHALL load the output register with sr as updated in that same cycle (a simultaneous shift is included).
REQ-019 On a latch edge SHALL set frame_err if the effective bit count (including a simultaneous shift) is not CHANNELS.
REQ-020 On a latch edge SHALL reset bit_cnt to 0 (or to 1 if a shift occurs in the same cycle, counting that bit toward the next frame only when no latch occurs; with latch it is counted in the current frame and bit_cnt becomes 0).
REQ-021 On a latch edge SHALL increment frame_cnt, wrapping modulo 2^FCNT_W.
REQ-022 SHALL drive pwm = output register when oe=1, all zeros when oe=0 (combinational gate, output register unaffected).
REQ-023 clr SHALL zero sr and bit_cnt next edge, take priority over shift_en, and leave the output register, frame_cnt and frame_err unchanged.
REQ-024 clr coincident with a latch edge SHALL transfer the pre-clear sr value and evaluate frame_err on the pre-clear count.
REQ-025 err_clr SHALL clear frame_err next edge; if a new error is detected in the same cycle, set wins.
REQ-026 The output register SHALL change only on a latch edge or reset; pwm is glitch-free between latches.

Reset
REQ-027 reset_n low SHALL asynchronously clear sr, bit_cnt, output register, latch_q, frame_cnt and frame_err to 0; pwm therefore reads 0.
REQ-028 Reset release SHALL be sampled at a clk edge; a frame in progress at reset is discarded, and the first frame after release starts at bit_cnt=0.

Structure
REQ-029 Shared package pwm_pkg SHALL hold the CHANNELS default (10) and FCNT_W default (8), used by both this block and the PWM generator.
REQ-030 Latch edge detection SHALL be a sub-module latch_edge_detect (registered input, one-cycle pulse output, async active-low reset).

Verification
REQ-031 Shift 1,0,1,1,0,0,0,0,0,1 then latch, oe=1 -> pwm = 10'b1011000001, frame_err=0, frame_cnt=1.
REQ-032 Shift 8 bits then latch -> frame_err=1 and pwm loaded with the 8 bits (low bits) plus the two older bits (high bits); err_clr -> frame_err=0 next cycle.
REQ-033 Shift 9 bits, then 10th shift with latch in the same cycle -> full 10-bit frame transferred, frame_err=0, bit_cnt=0.
REQ-034 latch held high 5 cycles -> frame_cnt increments by 1 only; 256 latches -> frame_cnt wraps to 0.
REQ-035 Load frame 10'h3FF, oe=0 -> pwm=0; oe=1 -> pwm=10'h3FF; clr mid-frame -> pwm still 10'h3FF.
REQ-036 reset_n asserted mid-frame between clock edges -> pwm, frame_cnt, frame_err become 0 immediately, without waiting for a clk edge.
